// File: rtl/xing_word_arbiter_if.sv
// ============================================================================
// xing_word_arbiter_if : requester bundle and synchronizer-side outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface xing_word_arbiter_if #(
  parameter int N = 4,
  parameter int S = 12
);
  localparam int CHW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*S-1:0] data;
  logic [N-1:0]   ack;
  logic [S-1:0]   xing_data;
  logic [CHW-1:0] xing_chan;
  logic           xing_valid;
  logic           busy;

  // Requester side drives the words; the arbiter drives the crossing side.
  modport master (
    output req, data,
    input  ack, xing_data, xing_chan, xing_valid, busy
  );

  modport slave (
    input  req, data,
    output ack, xing_data, xing_chan, xing_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/xing_word_arbiter.sv
// ============================================================================
// xing_word_arbiter : round-robin scheduler feeding one fast-to-slow word sync
// Rev 1.0
// ============================================================================
`default_nettype none

module xing_word_arbiter #(
  parameter int N    = 4,
  parameter int S    = 12,
  parameter int HOLD = 8,
  parameter int GAP  = 2
) (
  input  wire                   clk,
  input  wire                   reset,
  xing_word_arbiter_if.slave    bus
);
  localparam int IW   = $clog2(N);
  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  last;
  logic [N-1:0]   ack;
  logic [S-1:0]   xing_data;
  logic [IW-1:0]  xing_chan;
  logic           xing_valid;
  logic           busy;

  logic           win_found;
  logic [IW-1:0]  win_idx;

  // Search starts just past the previous winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!win_found && bus.req[(int'(last) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(last) + k) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last       <= IW'(N - 1);
      ack        <= '0;
      xing_data  <= '0;
      xing_chan  <= '0;
      xing_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            xing_data  <= bus.data[win_idx*S +: S];
            xing_chan  <= win_idx;
            xing_valid <= 1'b1;
            ack        <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            last       <= win_idx;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt == CW'(HOLD - 1)) begin
            xing_valid <= 1'b0;
            cnt        <= '0;
            state      <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == CW'(GAP - 1)) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt        <= '0;
          xing_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = ack;
  assign bus.xing_data  = xing_data;
  assign bus.xing_chan  = xing_chan;
  assign bus.xing_valid = xing_valid;
  assign bus.busy       = busy;

endmodule

`default_nettype wire

// File: tb/tb_xing_word_arbiter.sv
// ============================================================================
// tb_xing_word_arbiter : directed + random stimulus against a timeline model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_xing_word_arbiter;
  localparam int N    = 4;
  localparam int S    = 12;
  localparam int HOLD = 8;
  localparam int GAP  = 2;
  localparam int CHW  = $clog2(N);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xing_word_arbiter_if #(.N(N), .S(S)) bus ();

  xing_word_arbiter #(.N(N), .S(S), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: each grant is a point in time; outputs follow from elapsed cycles.
  int             cyc     = 0;
  int             m_grant = -100000;
  int             m_free  = 0;
  int             m_last  = N - 1;
  logic [S-1:0]   m_data  = '0;
  int             m_chan  = 0;
  logic [N-1:0]   m_ack   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    cyc++;
    m_ack = '0;
    if (reset) begin
      m_last  = N - 1;
      m_data  = '0;
      m_chan  = 0;
      m_grant = -100000;
      m_free  = cyc + 1;
    end else if (cyc >= m_free && bus.req != '0) begin
      int win = -1;
      for (int k = 1; k <= N; k++) begin
        int i = (m_last + k) % N;
        if (win < 0 && bus.req[i]) win = i;
      end
      m_grant     = cyc;
      m_free      = cyc + HOLD + GAP + 1;
      m_ack[win]  = 1'b1;
      m_data      = bus.data[win*S +: S];
      m_chan      = win;
      m_last      = win;
    end
  endtask

  task automatic check_all();
    int el = cyc - m_grant;
    chk("ack",        32'(bus.ack),        32'(m_ack));
    chk("xing_valid", 32'(bus.xing_valid), 32'(el < HOLD));
    chk("busy",       32'(bus.busy),       32'(el < HOLD + GAP));
    chk("xing_data",  32'(bus.xing_data),  32'(m_data));
    chk("xing_chan",  32'(bus.xing_chan),  32'(m_chan));
  endtask

  task automatic step(input logic rst_in, input logic [N-1:0] r, input logic [N*S-1:0] d);
    reset    = rst_in;
    bus.req  = r;
    bus.data = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [N*S-1:0] pack(input logic [S-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  logic [N*S-1:0] rd;
  logic [N-1:0]   rr;

  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus.data = '0;
    @(negedge clk);

    // Reset state
    step(1'b1, 4'b0000, '0);
    step(1'b1, 4'b0000, '0);

    // Single request on channel 2
    step(1'b0, 4'b0100, pack(12'h000, 12'h000, 12'hA5C, 12'h000));
    chk("t1_chan", 32'(bus.xing_chan), 32'd2);
    chk("t1_data", 32'(bus.xing_data), 32'hA5C);
    repeat (13) step(1'b0, 4'b0000, pack(12'h000, 12'h000, 12'hA5C, 12'h000));

    // Fairness under full load
    repeat (70) step(1'b0, 4'b1111, pack(12'h111, 12'h222, 12'h333, 12'h444));

    // Simultaneous contention straight after reset
    step(1'b1, 4'b0000, '0);
    step(1'b0, 4'b1010, pack(12'h0AA, 12'h0B1, 12'h0CC, 12'h0D3));
    chk("t3_first", 32'(bus.ack), 32'b0010);
    repeat (24) step(1'b0, 4'b1010, pack(12'h0AA, 12'h0B1, 12'h0CC, 12'h0D3));
    repeat (12) step(1'b0, 4'b0000, '0);

    // Data stability after capture
    step(1'b0, 4'b0001, pack(12'h123, 12'h0, 12'h0, 12'h0));
    repeat (12) step(1'b0, 4'b0000, pack(12'hFFF, 12'h0, 12'h0, 12'h0));
    chk("t4_data", 32'(bus.xing_data), 32'h123);

    // Withdrawn request during another requester's window
    step(1'b0, 4'b0001, pack(12'h321, 12'h0, 12'h0, 12'h777));
    repeat (3) step(1'b0, 4'b0000, pack(12'h321, 12'h0, 12'h0, 12'h777));
    repeat (3) step(1'b0, 4'b1000, pack(12'h321, 12'h0, 12'h0, 12'h777));
    repeat (10) step(1'b0, 4'b0000, pack(12'h321, 12'h0, 12'h0, 12'h777));
    chk("t5_busy", 32'(bus.busy), 32'd0);

    // Reset mid-hold, then full load restarts at channel 0
    step(1'b0, 4'b0100, pack(12'h0, 12'h0, 12'h5E5, 12'h0));
    repeat (3) step(1'b0, 4'b0000, pack(12'h0, 12'h0, 12'h5E5, 12'h0));
    step(1'b1, 4'b1111, pack(12'h9, 12'h8, 12'h7, 12'h6));
    step(1'b0, 4'b1111, pack(12'h9, 12'h8, 12'h7, 12'h6));
    chk("t6_chan", 32'(bus.xing_chan), 32'd0);
    repeat (15) step(1'b0, 4'b1111, pack(12'h9, 12'h8, 12'h7, 12'h6));

    // Random traffic with occasional resets
    rr = '0;
    rd = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) rr = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) rd[i*S +: S] = S'($urandom);
      step(($urandom_range(0, 59) == 0), rr, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
